// File: rtl/axis_frame_fifo_pkg.sv
// Shared constants for the store-and-forward AXI-Stream frame FIFO.
package axis_frame_fifo_pkg;

    // Entry layout is {tlast, tuser, tdata}; these offsets sit just above tdata.
    localparam int unsigned TUSER_BIT        = 0;
    localparam int unsigned TLAST_BIT        = 1;
    localparam int unsigned ENTRY_EXTRA_BITS = 2;

    // One extra pointer bit separates a full buffer from an empty one.
    localparam int unsigned PTR_EXTRA_BITS   = 1;

endpackage

// File: rtl/axis_frame_fifo_ram.sv
// Simple dual-port RAM: synchronous write port, registered synchronous read port.
module axis_frame_fifo_ram #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned WIDTH      = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // The read register doubles as the output stage, so it is reset; the array is not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO; drops overflowing frames.
// AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN: also drop frames flagged by tuser on tlast.
module axis_frame_fifo
    import axis_frame_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned DROP_WHEN_FULL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic                  overflow,
    output logic                  bad_frame,
    output logic                  good_frame
);

    localparam int unsigned PW    = ADDR_WIDTH + PTR_EXTRA_BITS;
    localparam int unsigned EW    = DATA_WIDTH + ENTRY_EXTRA_BITS;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic          DROP_FULL = (DROP_WHEN_FULL != 0);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] wr_ptr_cur_q, wr_ptr_cur_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          drop_frame_q, drop_frame_d;
    logic          out_valid_q, out_valid_d;
    logic          overflow_q, overflow_d;
    logic          bad_frame_q, bad_frame_d;
    logic          good_frame_q, good_frame_d;

    logic [PW-1:0] used_all, used_cur;
    logic          full, full_wr, empty;
    logic          in_fire, wr_en, rd_en, stored_tuser;
    logic [EW-1:0] wr_data, rd_data;

    always_comb begin
        used_all = wr_ptr_cur_q - rd_ptr_q;
        used_cur = wr_ptr_cur_q - wr_ptr_q;
        full     = (used_all == DEPTH_PTR);
        full_wr  = (used_cur == DEPTH_PTR);
        empty    = (rd_ptr_q == wr_ptr_q);
    end

    assign input_axis_tready = ~full | full_wr | drop_frame_q | DROP_FULL;
    assign in_fire           = input_axis_tvalid & input_axis_tready;

`ifdef AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN
    assign stored_tuser = 1'b0;
`else
    assign stored_tuser = input_axis_tuser;
`endif

    assign wr_data = {input_axis_tlast, stored_tuser, input_axis_tdata};

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        wr_ptr_cur_d = wr_ptr_cur_q;
        drop_frame_d = drop_frame_q;
        overflow_d   = 1'b0;
        bad_frame_d  = 1'b0;
        good_frame_d = 1'b0;
        wr_en        = 1'b0;
        if (in_fire) begin
            if (drop_frame_q) begin
                if (input_axis_tlast) begin
                    drop_frame_d = 1'b0;
                end
            end else if (full) begin
                wr_ptr_cur_d = wr_ptr_q;
                overflow_d   = 1'b1;
                if (!input_axis_tlast) begin
                    drop_frame_d = 1'b1;
                end
            end else begin
                wr_en        = 1'b1;
                wr_ptr_cur_d = wr_ptr_cur_q + PTR_ONE;
                if (input_axis_tlast) begin
`ifdef AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN
                    if (input_axis_tuser) begin
                        wr_ptr_cur_d = wr_ptr_q;
                        bad_frame_d  = 1'b1;
                    end else begin
                        wr_ptr_d     = wr_ptr_cur_q + PTR_ONE;
                        good_frame_d = 1'b1;
                    end
`else
                    wr_ptr_d     = wr_ptr_cur_q + PTR_ONE;
                    good_frame_d = 1'b1;
`endif
                end
            end
        end
    end

    // The RAM read register is the output stage: refill whenever it is empty or draining.
    always_comb begin
        rd_en       = ~empty & (~out_valid_q | output_axis_tready);
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        if (rd_en) begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            out_valid_d = 1'b1;
        end else if (output_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            wr_ptr_cur_q <= '0;
            rd_ptr_q     <= '0;
            drop_frame_q <= 1'b0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            bad_frame_q  <= 1'b0;
            good_frame_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_ptr_cur_q <= wr_ptr_cur_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_frame_q <= drop_frame_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            bad_frame_q  <= bad_frame_d;
            good_frame_q <= good_frame_d;
        end
    end

    axis_frame_fifo_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .WIDTH     (EW)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr_cur_q[ADDR_WIDTH-1:0]),
        .wr_data(wr_data),
        .rd_en  (rd_en),
        .rd_addr(rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data(rd_data)
    );

    assign output_axis_tdata  = rd_data[DATA_WIDTH-1:0];
    assign output_axis_tuser  = rd_data[DATA_WIDTH+TUSER_BIT];
    assign output_axis_tlast  = rd_data[DATA_WIDTH+TLAST_BIT];
    assign output_axis_tvalid = out_valid_q;
    assign overflow           = overflow_q;
    assign bad_frame          = bad_frame_q;
    assign good_frame         = good_frame_q;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed self-checking bench for axis_frame_fifo (both DROP_WHEN_FULL settings).
module tb_axis_frame_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    // DUT A: DROP_WHEN_FULL = 0
    logic [7:0] a_tdata;
    logic       a_tvalid, a_tready, a_tlast, a_tuser;
    logic [7:0] a_odata;
    logic       a_ovalid, a_oready, a_olast, a_ouser, a_ovf, a_bad, a_good;
    // DUT B: DROP_WHEN_FULL = 1
    logic [7:0] b_tdata;
    logic       b_tvalid, b_tready, b_tlast, b_tuser;
    logic [7:0] b_odata;
    logic       b_ovalid, b_oready, b_olast, b_ouser, b_ovf, b_bad, b_good;

    axis_frame_fifo #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DROP_WHEN_FULL(0)) dut_a (
        .clk(clk), .rst(rst_n),
        .input_axis_tdata(a_tdata), .input_axis_tvalid(a_tvalid), .input_axis_tready(a_tready),
        .input_axis_tlast(a_tlast), .input_axis_tuser(a_tuser),
        .output_axis_tdata(a_odata), .output_axis_tvalid(a_ovalid), .output_axis_tready(a_oready),
        .output_axis_tlast(a_olast), .output_axis_tuser(a_ouser),
        .overflow(a_ovf), .bad_frame(a_bad), .good_frame(a_good)
    );

    axis_frame_fifo #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DROP_WHEN_FULL(1)) dut_b (
        .clk(clk), .rst(rst_n),
        .input_axis_tdata(b_tdata), .input_axis_tvalid(b_tvalid), .input_axis_tready(b_tready),
        .input_axis_tlast(b_tlast), .input_axis_tuser(b_tuser),
        .output_axis_tdata(b_odata), .output_axis_tvalid(b_ovalid), .output_axis_tready(b_oready),
        .output_axis_tlast(b_olast), .output_axis_tuser(b_ouser),
        .overflow(b_ovf), .bad_frame(b_bad), .good_frame(b_good)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         tlast_cyc = 0;
    int         rise_cyc  = 0;
    int         stab_err  = 0;
    int         good_a = 0, ovf_a = 0, bad_a = 0, good_b = 0, ovf_b = 0, b_ready_low = 0;
    int         rmode = 0;
    int         pcnt  = 0;
    logic [3:0] pat   = 4'b1001;
    logic [7:0] fbuf [0:127];
    logic [9:0] got_a [$];
    logic [9:0] got_b [$];
    logic       a_prev_v = 1'b0;
    logic       a_prev_stall = 1'b0;
    logic [9:0] a_prev_beat = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        pcnt++;
        case (rmode)
            0:       a_oready = 1'b1;
            2:       a_oready = 1'b0;
            default: a_oready = pat[pcnt % 4];
        endcase
    end

    // Monitor samples late in the low phase, just before the edge that completes a handshake.
    always begin
        @(negedge clk);
        #4;
        if (a_ovalid && a_oready) got_a.push_back({a_olast, a_ouser, a_odata});
        if (b_ovalid && b_oready) got_b.push_back({b_olast, b_ouser, b_odata});
        if (a_ovalid && !a_prev_v) rise_cyc = cyc;
        if (a_prev_stall && rst_n) begin
            if (!a_ovalid || ({a_olast, a_ouser, a_odata} != a_prev_beat)) stab_err++;
        end
        a_prev_v     = a_ovalid;
        a_prev_stall = a_ovalid && !a_oready;
        a_prev_beat  = {a_olast, a_ouser, a_odata};
        if (a_good) good_a++;
        if (a_ovf)  ovf_a++;
        if (a_bad)  bad_a++;
        if (b_good) good_b++;
        if (b_ovf)  ovf_b++;
    end

    // Called at a negedge; returns at the negedge after the last beat is accepted.
    task automatic send(input int which, input int off, input int len, input bit user);
        for (int i = 0; i < len; i++) begin
            logic lst;
            int   t;
            lst = (i == len - 1);
            if (which == 0) begin
                a_tdata = fbuf[off+i]; a_tvalid = 1'b1; a_tlast = lst; a_tuser = lst & user;
            end else begin
                b_tdata = fbuf[off+i]; b_tvalid = 1'b1; b_tlast = lst; b_tuser = lst & user;
                if (!b_tready) b_ready_low++;
            end
            t = 0;
            while (!((which == 0) ? a_tready : b_tready) && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) check("in_tready_timeout", 32'(0), 32'(1));
            @(posedge clk);
            @(negedge clk);
            if (lst) tlast_cyc = cyc;
        end
        a_tvalid = 1'b0; a_tlast = 1'b0; a_tuser = 1'b0;
        b_tvalid = 1'b0; b_tlast = 1'b0; b_tuser = 1'b0;
    endtask

    task automatic wait_got(input int which, input int target);
        for (int t = 0; t < 400; t++) begin
            if (((which == 0) ? got_a.size() : got_b.size()) >= target) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic cmp_frame(input int which, input int base, input int off, input int len,
                             input bit user, input string tag);
        int         n;
        logic [9:0] e, g;
        n = (which == 0) ? got_a.size() : got_b.size();
        check({tag, "_len"}, 32'(n - base), 32'(len));
        for (int i = 0; i < len; i++) begin
            if (base + i < n) begin
                e = {(i == len - 1), user && (i == len - 1), fbuf[off+i]};
                g = (which == 0) ? got_a[base+i] : got_b[base+i];
                check({tag, "_beat"}, 32'(g), 32'(e));
            end
        end
    endtask

    task automatic load_cdab(input int off);
        logic [7:0] v [0:4];
        v[0] = 8'hcd; v[1] = 8'hab; v[2] = 8'hcd; v[3] = 8'hab; v[4] = 8'hcd;
        for (int i = 0; i < 5; i++) fbuf[off+i] = v[i];
    endtask

    initial begin
        int base, g0, o0, b0, l0;
        rst_n = 1'b0;
        a_tdata = '0; a_tvalid = 1'b0; a_tlast = 1'b0; a_tuser = 1'b0;
        b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0; b_tuser = 1'b0;
        b_oready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_a_out", 32'({a_ovalid, a_olast, a_ouser, a_odata}), 32'(0));
        check("rst_a_pulses", 32'({a_ovf, a_bad, a_good}), 32'(0));
        check("rst_a_tready", 32'(a_tready), 32'(1));
        check("rst_b_out", 32'({b_ovalid, b_olast, b_ouser, b_odata}), 32'(0));
        check("rst_b_tready", 32'(b_tready), 32'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // 5-byte frame, output always ready
        load_cdab(0);
        base = got_a.size(); g0 = good_a;
        send(0, 0, 5, 1'b0);
        wait_got(0, base + 5);
        cmp_frame(0, base, 0, 5, 1'b0, "basic");
        check("basic_good", 32'(good_a - g0), 32'(1));
        check("basic_latency", 32'(rise_cyc - tlast_cyc), 32'(1));

        // Same frame with output ready toggling 1,0,0,1
        rmode = 1;
        base = got_a.size(); g0 = good_a;
        send(0, 0, 5, 1'b0);
        wait_got(0, base + 5);
        cmp_frame(0, base, 0, 5, 1'b0, "stall");
        check("stall_good", 32'(good_a - g0), 32'(1));
        rmode = 0;
        @(negedge clk);

        // 70-byte frame overflows a 64-entry buffer, then a 5-byte frame
        for (int i = 0; i < 70; i++) fbuf[i] = 8'(i);
        base = got_a.size(); g0 = good_a; o0 = ovf_a;
        send(0, 0, 70, 1'b0);
        for (int i = 0; i < 5; i++) fbuf[i] = 8'(8'h50 + i);
        send(0, 0, 5, 1'b0);
        wait_got(0, base + 5);
        cmp_frame(0, base, 0, 5, 1'b0, "ovf");
        check("ovf_pulse", 32'(ovf_a - o0), 32'(1));
        check("ovf_good", 32'(good_a - g0), 32'(1));

        // Frame flagged bad on tlast
        load_cdab(0);
        base = got_a.size(); g0 = good_a; b0 = bad_a;
        send(0, 0, 5, 1'b1);
`ifdef AXIS_FRAME_FIFO_DROP_BAD_FRAME_EN
        repeat (10) @(negedge clk);
        check("bad_len", 32'(got_a.size() - base), 32'(0));
        check("bad_pulse", 32'(bad_a - b0), 32'(1));
        check("bad_good", 32'(good_a - g0), 32'(0));
`else
        wait_got(0, base + 5);
        cmp_frame(0, base, 0, 5, 1'b1, "bad");
        check("bad_pulse", 32'(bad_a - b0), 32'(0));
        check("bad_good", 32'(good_a - g0), 32'(1));
`endif

        // DROP_WHEN_FULL=1: 60 committed bytes stalled, then a 10-byte frame
        b_oready = 1'b0;
        for (int i = 0; i < 60; i++) fbuf[i] = 8'(8'ha0 + i);
        for (int i = 0; i < 10; i++) fbuf[64+i] = 8'(8'h30 + i);
        base = got_b.size(); g0 = good_b; o0 = ovf_b; l0 = b_ready_low;
        send(1, 0, 60, 1'b0);
        send(1, 64, 10, 1'b0);
        repeat (5) @(negedge clk);
        check("dwf_tready", 32'(b_ready_low - l0), 32'(0));
        check("dwf_ovf", 32'(ovf_b - o0), 32'(1));
        check("dwf_good", 32'(good_b - g0), 32'(1));
        check("dwf_held_valid", 32'(b_ovalid), 32'(1));
        check("dwf_held_data", 32'(b_odata), 32'(8'ha0));
        b_oready = 1'b1;
        wait_got(1, base + 60);
        cmp_frame(1, base, 0, 60, 1'b0, "dwf");

        // Reset mid-output
        rmode = 2;
        load_cdab(0);
        send(0, 0, 5, 1'b0);
        repeat (2) @(negedge clk);
        check("rstmid_valid_before", 32'(a_ovalid), 32'(1));
        check("rstmid_data_before", 32'(a_odata), 32'(8'hcd));
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_valid_async", 32'(a_ovalid), 32'(0));
        check("rstmid_data_async", 32'(a_odata), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rmode = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) fbuf[i] = 8'(8'h71 + i);
        base = got_a.size();
        send(0, 0, 5, 1'b0);
        wait_got(0, base + 5);
        cmp_frame(0, base, 0, 5, 1'b0, "after_rst");

        check("stall_stable", 32'(stab_err), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
